// File: rtl/adapter_dl_pack.sv
// adapter_dl_pack: serialises wide parallel IQ vectors into 32-bit {Q,I} words
// through a FIFO and releases them at a programmable pace after a prefill level.
module adapter_dl_pack #(
  parameter int IQ_BIT_WIDTH    = 16,
  parameter int NUM_LANES       = 8,
  parameter int FIFO_ADDR_WIDTH = 4,
  parameter int SIGN_EXTEND     = 0,
  parameter int READ_INTERVAL   = 4,
  parameter int PREFILL_LEVEL   = 8
) (
  input  logic                              clk_1,
  input  logic                              rst,
  input  logic                              iq_rx_data_valid,
  input  logic [NUM_LANES*IQ_BIT_WIDTH-1:0] iq_rx_i,
  input  logic [NUM_LANES*IQ_BIT_WIDTH-1:0] iq_rx_q,
  output logic                              in_ready,
  output logic [31:0]                       adapter_data_out,
  output logic                              adapter_data_valid,
  input  logic                              adapter_data_ready,
  output logic [FIFO_ADDR_WIDTH:0]          fifo_level,
  output logic                              overflow,
  output logic                              underrun,
  input  logic                              status_clr
);
  localparam int W = IQ_BIT_WIDTH;
  localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
  localparam int LW = $clog2(NUM_LANES);
  typedef enum logic {IDLE, SHIFT} cap_t;
  typedef enum logic {PREFILL, STREAM} rd_t;
  cap_t cap;
  rd_t rd;
  logic [LW-1:0] lane;
  logic [NUM_LANES*W-1:0] i_reg, q_reg;
  logic [31:0] mem [DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wp, rp;
  logic [7:0] pace;
  logic full, empty, last, push, pop, free, accept, drop, starve;
  logic [W-1:0] i_s, q_s;
  logic [31:0] word;
  function automatic logic [15:0] ext16(input logic [W-1:0] s);
    return SIGN_EXTEND != 0 ? 16'($signed(s)) : 16'(s);
  endfunction
  assign full = fifo_level == (FIFO_ADDR_WIDTH+1)'(DEPTH);
  assign empty = fifo_level == '0;
  assign last = lane == LW'(NUM_LANES - 1);
  assign in_ready = ~rst & (cap == IDLE | (cap == SHIFT & last & ~full));
  assign accept = iq_rx_data_valid & in_ready;
  assign drop = iq_rx_data_valid & ~in_ready;
  assign push = cap == SHIFT & ~full;
  assign i_s = i_reg[lane*W +: W];
  assign q_s = q_reg[lane*W +: W];
  assign word = {ext16(q_s), ext16(i_s)};
  assign free = ~adapter_data_valid | adapter_data_ready;
  assign pop = rd == STREAM & pace == '0 & ~empty & free;
  assign starve = rd == STREAM & pace == '0 & empty & free;
  always_ff @(posedge clk_1)
    if (push) mem[wp] <= word;
  always_ff @(posedge clk_1)
    if (rst) begin
      cap <= IDLE;
      rd <= PREFILL;
      lane <= '0;
      pace <= '0;
      wp <= '0;
      rp <= '0;
      fifo_level <= '0;
      adapter_data_out <= '0;
      adapter_data_valid <= 1'b0;
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (accept) begin
        i_reg <= iq_rx_i;
        q_reg <= iq_rx_q;
        cap <= SHIFT;
        lane <= '0;
      end else if (push) begin
        lane <= lane + 1'b1;
        if (last) cap <= IDLE;
      end
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      fifo_level <= fifo_level + (FIFO_ADDR_WIDTH+1)'(push) - (FIFO_ADDR_WIDTH+1)'(pop);
      if (rd == PREFILL) begin
        if (fifo_level >= (FIFO_ADDR_WIDTH+1)'(PREFILL_LEVEL)) rd <= STREAM;
      end else begin
        if (pop) pace <= 8'(READ_INTERVAL - 1);
        else if (pace != '0) pace <= pace - 1'b1;
        if (starve) rd <= PREFILL;
      end
      if (pop) begin
        adapter_data_out <= mem[rp];
        adapter_data_valid <= 1'b1;
      end else if (adapter_data_ready) adapter_data_valid <= 1'b0;
      // a same-cycle set event outranks status_clr
      overflow <= drop | (overflow & ~status_clr);
      underrun <= starve | (underrun & ~status_clr);
    end
endmodule

// File: tb/tb_adapter_dl_pack.sv
// tb_adapter_dl_pack: directed steps with random lane data, checked against a
// word-queue model built from the sample-extension rules.
module tb_adapter_dl_pack;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  int total = 0, bad = 0, cyc = 0, acc_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic v0 = 0, dr0 = 1, clr0 = 0, ir0, dv0, ov0, ur0;
  logic [127:0] i0 = '0, q0 = '0;
  logic [31:0] do0;
  logic [4:0] lv0;
  logic v1 = 0, dr1 = 1, clr1 = 0, ir1, dv1, ov1, ur1;
  logic [95:0] i1 = '0, q1 = '0;
  logic [31:0] do1;
  logic [4:0] lv1;
  logic v2 = 0, dr2 = 1, clr2 = 0, ir2, dv2, ov2, ur2;
  logic [95:0] i2 = '0, q2 = '0;
  logic [31:0] do2;
  logic [4:0] lv2;
  adapter_dl_pack d0 (
    .clk_1(clk), .rst(rst), .iq_rx_data_valid(v0), .iq_rx_i(i0), .iq_rx_q(q0),
    .in_ready(ir0), .adapter_data_out(do0), .adapter_data_valid(dv0),
    .adapter_data_ready(dr0), .fifo_level(lv0), .overflow(ov0), .underrun(ur0),
    .status_clr(clr0));
  adapter_dl_pack #(.IQ_BIT_WIDTH(12), .SIGN_EXTEND(1), .READ_INTERVAL(1), .PREFILL_LEVEL(1)) d1 (
    .clk_1(clk), .rst(rst), .iq_rx_data_valid(v1), .iq_rx_i(i1), .iq_rx_q(q1),
    .in_ready(ir1), .adapter_data_out(do1), .adapter_data_valid(dv1),
    .adapter_data_ready(dr1), .fifo_level(lv1), .overflow(ov1), .underrun(ur1),
    .status_clr(clr1));
  adapter_dl_pack #(.IQ_BIT_WIDTH(12), .SIGN_EXTEND(0), .READ_INTERVAL(4), .PREFILL_LEVEL(4)) d2 (
    .clk_1(clk), .rst(rst), .iq_rx_data_valid(v2), .iq_rx_i(i2), .iq_rx_q(q2),
    .in_ready(ir2), .adapter_data_out(do2), .adapter_data_valid(dv2),
    .adapter_data_ready(dr2), .fifo_level(lv2), .overflow(ov2), .underrun(ur2),
    .status_clr(clr2));
  logic [31:0] e0[$], e1[$], e2[$];
  int t0[$], t1[$], t2[$];
  logic [15:0] vi[8], vq[8];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  function automatic logic [15:0] ext(input logic [15:0] s, input int w, input bit se);
    int v;
    v = int'(s) & ((1 << w) - 1);
    if (se && v >= (1 << (w - 1))) v = v - (1 << w);
    return 16'(v);
  endfunction
  task automatic rand_vec();
    for (int k = 0; k < 8; k++) begin
      vi[k] = 16'($urandom);
      vq[k] = 16'($urandom);
    end
  endtask
  task automatic send(input int d, input bit acc);
    int w;
    bit se;
    logic r;
    logic [31:0] x;
    w = d == 0 ? 16 : 12;
    se = d == 1;
    for (int k = 0; k < 8; k++) begin
      i0[k*16 +: 16] = vi[k];
      q0[k*16 +: 16] = vq[k];
      i1[k*12 +: 12] = vi[k][11:0];
      q1[k*12 +: 12] = vq[k][11:0];
      i2[k*12 +: 12] = vi[k][11:0];
      q2[k*12 +: 12] = vq[k][11:0];
    end
    if (d == 0) v0 = 1; else if (d == 1) v1 = 1; else v2 = 1;
    #1;
    r = d == 0 ? ir0 : d == 1 ? ir1 : ir2;
    chk($sformatf("d%0d in_ready at send", d), 32'(r), 32'(acc));
    tick(1);
    v0 = 0;
    v1 = 0;
    v2 = 0;
    acc_cyc = cyc;
    if (acc)
      for (int k = 0; k < 8; k++) begin
        x = {ext(vq[k], w, se), ext(vi[k], w, se)};
        if (d == 0) e0.push_back(x); else if (d == 1) e1.push_back(x); else e2.push_back(x);
      end
  endtask
  always @(negedge clk)
    if (!rst) begin
      if (dv0 && dr0) begin
        chk("d0 word expected", 32'(e0.size() > 0), 1);
        if (e0.size() > 0) chk("d0 word", do0, e0.pop_front());
        t0.push_back(cyc);
      end
      if (dv1 && dr1) begin
        chk("d1 word expected", 32'(e1.size() > 0), 1);
        if (e1.size() > 0) chk("d1 word", do1, e1.pop_front());
        t1.push_back(cyc);
      end
      if (dv2 && dr2) begin
        chk("d2 word expected", 32'(e2.size() > 0), 1);
        if (e2.size() > 0) chk("d2 word", do2, e2.pop_front());
        t2.push_back(cyc);
      end
    end
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    int a, n;
    tick(3);
    chk("reset in_ready", ir0, 0);
    chk("reset valid", dv0, 0);
    rst = 0;
    #1;
    chk("post-reset in_ready d0", ir0, 1);
    chk("post-reset in_ready d1", ir1, 1);
    chk("post-reset out", do0, 0);
    chk("post-reset level", lv0, 0);
    chk("post-reset flags", {ov0, ur0}, 0);
    // default stream: prefill 8, pace 4
    for (int k = 0; k < 8; k++) begin
      vi[k] = 16'h1000 + 16'(k);
      vq[k] = 16'h2000 + 16'(k);
    end
    send(0, 1);
    a = acc_cyc;
    tick(8);
    chk("d0 level before first pop", lv0, 8);
    chk("d0 no word before prefill", dv0, 0);
    tick(2);
    chk("d0 first valid", dv0, 1);
    chk("d0 first word literal", do0, 32'h2000_1000);
    chk("d0 level after first pop", lv0, 7);
    tick(36);
    chk("d0 word count", t0.size(), 8);
    chk("d0 first latency", t0[0] - a, 10);
    for (int k = 1; k < t0.size(); k++) chk("d0 spacing", t0[k] - t0[k-1], 4);
    chk("d0 queue drained", e0.size(), 0);
    chk("d0 underrun after stream", ur0, 1);
    clr0 = 1;
    tick(1);
    clr0 = 0;
    chk("d0 underrun cleared", ur0, 0);
    // back-pressure: fill FIFO, stall, drop the fourth vector
    t0.delete();
    dr0 = 0;
    rand_vec();
    send(0, 1);
    tick(7);
    rand_vec();
    send(0, 1);
    tick(7);
    rand_vec();
    send(0, 1);
    tick(3);
    chk("d0 full level", lv0, 16);
    rand_vec();
    send(0, 0);
    chk("d0 overflow set", ov0, 1);
    chk("d0 full level after drop", lv0, 16);
    chk("d0 held valid", dv0, 1);
    dr0 = 1;
    tick(120);
    chk("d0 drained queue", e0.size(), 0);
    chk("d0 drained count", t0.size(), 24);
    chk("d0 level empty", lv0, 0);
    chk("d0 overflow sticky", ov0, 1);
    clr0 = 1;
    tick(1);
    clr0 = 0;
    chk("d0 overflow cleared", ov0, 0);
    // sign extension, minimum latency
    rand_vec();
    vi[0] = 16'h0800;
    vq[0] = 16'h07FF;
    send(1, 1);
    a = acc_cyc;
    tick(2);
    chk("d1 no valid at cycle 3", dv1, 0);
    tick(1);
    chk("d1 valid at cycle 4", dv1, 1);
    chk("d1 sign-extended word", do1, 32'h07FF_F800);
    tick(15);
    chk("d1 latency", t1[0] - a, 3);
    chk("d1 queue drained", e1.size(), 0);
    chk("d1 underrun", ur1, 1);
    clr1 = 1;
    tick(1);
    clr1 = 0;
    // back-to-back vectors
    t1.delete();
    rand_vec();
    send(1, 1);
    tick(7);
    rand_vec();
    send(1, 1);
    tick(25);
    chk("d1 b2b count", t1.size(), 16);
    for (int k = 1; k < t1.size(); k++) chk("d1 b2b contiguous", t1[k] - t1[k-1], 1);
    chk("d1 b2b no overflow", ov1, 0);
    chk("d1 b2b drained", e1.size(), 0);
    // zero extension and underrun with prefill 4
    rand_vec();
    vi[0] = 16'h0800;
    vq[0] = 16'h07FF;
    send(2, 1);
    a = acc_cyc;
    tick(6);
    chk("d2 first valid", dv2, 1);
    chk("d2 zero-extended word", do2, 32'h07FF_0800);
    tick(31);
    chk("d2 no underrun yet", ur2, 0);
    tick(1);
    chk("d2 underrun set", ur2, 1);
    chk("d2 count", t2.size(), 8);
    chk("d2 latency", t2[0] - a, 6);
    chk("d2 drained", e2.size(), 0);
    t2.delete();
    rand_vec();
    send(2, 1);
    a = acc_cyc;
    tick(3);
    chk("d2 refill level 3", lv2, 3);
    chk("d2 waits for prefill", dv2, 0);
    tick(1);
    chk("d2 refill level 4", lv2, 4);
    tick(40);
    chk("d2 refill latency", t2[0] - a, 6);
    chk("d2 refill drained", e2.size(), 0);
    // reset mid-vector
    rand_vec();
    send(0, 1);
    tick(5);
    chk("d0 level before reset", lv0, 5);
    rst = 1;
    tick(1);
    chk("d0 level in reset", lv0, 0);
    chk("d0 valid in reset", dv0, 0);
    chk("d0 in_ready in reset", ir0, 0);
    e0.delete();
    rst = 0;
    #1;
    chk("d0 in_ready after reset", ir0, 1);
    n = t0.size();
    tick(30);
    chk("d0 no stale words", t0.size(), n);
    chk("d0 level stays empty", lv0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
